// File: rtl/fir_pkg.sv
// Shared defaults and saturation helpers for the FIR decimator slice.
package fir_pkg;
  localparam int IN_W_DEF  = 16;
  localparam int OUT_W_DEF = 8;
  localparam int DECIM_DEF = 4;
  localparam int SHIFT_DEF = 5;
  localparam int DEPTH_DEF = 4;

  localparam int SAT_MAX_DEF = (2 ** (OUT_W_DEF - 1)) - 1;
  localparam int SAT_MIN_DEF = -(2 ** (OUT_W_DEF - 1));

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted only
// when a pop happens in the same cycle; the read side never bypasses the write.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    empty    = (count_q == '0);
    do_pop   = rd_en && !empty;
    do_push  = wr_en && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  // Empty reads return zero so the head output is clean straight after reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
  assign level   = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fir_decimator.sv
// Block-sum decimator: adds DECIM valid samples, rounds half-up, saturates and
// queues the result. Output handshake: dout is held while dout_valid=1 and
// dout_ready=0; an entry leaves the FIFO on any cycle with both high.
module fir_decimator
  import fir_pkg::*;
#(
  parameter int IN_W  = IN_W_DEF,
  parameter int OUT_W = OUT_W_DEF,
  parameter int DECIM = DECIM_DEF,
  parameter int SHIFT = SHIFT_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_W-1:0]      din,
  input  logic                        din_valid,
  output logic signed [OUT_W-1:0]     dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        ovf,
  input  logic                        ovf_clr
);
  localparam int ACC_W = IN_W + $clog2(DECIM);
  localparam int PH_W  = $clog2(DECIM);
  localparam logic signed [ACC_W:0] RND    = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(sat_max(OUT_W));
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(sat_min(OUT_W));

  logic [PH_W-1:0]         phase_q, phase_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic signed [ACC_W-1:0] din_ext, sum;
  logic signed [ACC_W:0]   sum_r, rounded;
  logic [OUT_W-1:0]        sat;
  logic                    last, drop;
  logic                    fifo_full, fifo_empty;
  logic [OUT_W-1:0]        fifo_rd;

  always_comb begin
    din_ext = {{(ACC_W-IN_W){din[IN_W-1]}}, din};
    last    = din_valid && (phase_q == PH_W'(DECIM - 1));
    sum     = (phase_q == '0) ? din_ext : acc_q + din_ext;
    phase_d = phase_q;
    acc_d   = acc_q;
    if (din_valid) begin
      phase_d = last ? '0 : phase_q + PH_W'(1);
      acc_d   = last ? '0 : sum;
    end
    // One guard bit keeps the rounding add from wrapping at the positive limit.
    sum_r   = $signed({sum[ACC_W-1], sum}) + RND;
    rounded = sum_r >>> SHIFT;
    if (rounded > SAT_HI) begin
      sat = SAT_HI[OUT_W-1:0];
    end else if (rounded < SAT_LO) begin
      sat = SAT_LO[OUT_W-1:0];
    end else begin
      sat = rounded[OUT_W-1:0];
    end
    // Full implies non-empty, so dout_ready alone decides whether space frees up.
    drop  = last && fifo_full && !dout_ready;
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (last),
    .wr_data (sat),
    .rd_en   (dout_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign dout       = $signed(fifo_rd);
  assign dout_valid = !fifo_empty;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator at default parameters (DECIM=4, SHIFT=5, DEPTH=4).
module tb_fir_decimator;
  localparam int IN_W  = 16;
  localparam int OUT_W = 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic signed [IN_W-1:0]  din;
  logic                    din_valid;
  logic signed [OUT_W-1:0] dout;
  logic                    dout_valid;
  logic                    dout_ready;
  logic [2:0]              level;
  logic                    ovf;
  logic                    ovf_clr;

  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] exp_q[$];

  typedef struct {
    logic signed [IN_W-1:0] s0, s1, s2, s3;
    int                     exp;
  } vec_t;
  vec_t tbl[13];

  fir_decimator dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr)
  );

  // clock
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [IN_W-1:0] v);
    din       = v;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    din       = '0;
  endtask

  // scoreboard
  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string name);
    logic [OUT_W-1:0] e;
    check({name, "_valid"}, int'(dout_valid), 1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got %0d expected nothing queued", name, int'(dout));
    end else begin
      e = exp_q.pop_front();
      check(name, int'(dout), int'($signed(e)));
    end
  endtask

  initial begin
    tbl[0]  = '{16, 16, 16, 16, 2};
    tbl[1]  = '{4, 4, 4, 4, 1};
    tbl[2]  = '{-1, -1, -1, -1, 0};
    tbl[3]  = '{32767, 32767, 32767, 32767, 127};
    tbl[4]  = '{-32768, -32768, -32768, -32768, -128};
    tbl[5]  = '{12, 12, 12, 12, 2};
    tbl[6]  = '{-4, -4, -4, -4, 0};
    tbl[7]  = '{-12, -12, -12, -12, -1};
    tbl[8]  = '{10, 20, 30, 40, 3};
    tbl[9]  = '{-17, -17, -17, -17, -2};
    tbl[10] = '{1000, -1000, 500, 3000, 109};
    tbl[11] = '{2000, 2000, 100, 0, 127};
    tbl[12] = '{-4000, -96, 0, 0, -128};

    // reset block
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b1;
    ovf_clr    = 1'b0;
    tick();
    tick();
    check("rst_level", int'(level), 0);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    tick();

    // table vectors, downstream always ready
    for (int i = 0; i < 13; i++) begin
      send(tbl[i].s0);
      send(tbl[i].s1);
      send(tbl[i].s2);
      check($sformatf("vec%0d_early", i), int'(dout_valid), 0);
      send(tbl[i].s3);
      exp_q.push_back(OUT_W'(tbl[i].exp));
      check_out($sformatf("vec%0d_dout", i));
      check($sformatf("vec%0d_level", i), int'(level), 1);
      tick();
      check($sformatf("vec%0d_popped", i), int'(dout_valid), 0);
    end

    // backpressure: five blocks into a four-entry FIFO
    dout_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      send(16'sd32);
      if (i == 15) begin
        check("fill_level", int'(level), 4);
        check("fill_no_ovf", int'(ovf), 0);
      end
    end
    for (int i = 0; i < 4; i++) exp_q.push_back(OUT_W'(4));
    check("ovf_level", int'(level), 4);
    check("ovf_set", int'(ovf), 1);
    check("hold_dout", int'(dout), 4);

    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", int'(ovf), 0);

    // drop and clear in the same cycle: set wins
    send(16'sd32);
    send(16'sd32);
    send(16'sd32);
    ovf_clr = 1'b1;
    send(16'sd32);
    ovf_clr = 1'b0;
    check("set_wins", int'(ovf), 1);
    check("drop_level", int'(level), 4);

    // push while full with a pop in the same cycle
    send(16'sd16);
    send(16'sd16);
    send(16'sd16);
    dout_ready = 1'b1;
    check_out("pp_head");
    send(16'sd16);
    exp_q.push_back(OUT_W'(2));
    check("pp_level", int'(level), 4);
    check("pp_ovf", int'(ovf), 1);
    for (int i = 0; i < 4; i++) begin
      check_out($sformatf("drain%0d", i));
      tick();
    end
    check("drain_empty", int'(dout_valid), 0);
    check("drain_level", int'(level), 0);
    check("ovf_sticky", int'(ovf), 1);

    // reset mid-block, valid during reset ignored, then gapped samples
    send(16'sd8);
    send(16'sd8);
    rst       = 1'b1;
    din       = 16'sd8;
    din_valid = 1'b1;
    tick();
    rst       = 1'b0;
    din_valid = 1'b0;
    check("mid_rst_level", int'(level), 0);
    check("mid_rst_ovf", int'(ovf), 0);
    check("mid_rst_valid", int'(dout_valid), 0);
    for (int i = 0; i < 4; i++) begin
      send(16'sd8);
      if (i < 3) begin
        check($sformatf("gap%0d_idle", i), int'(dout_valid), 0);
        tick();
        tick();
      end
    end
    exp_q.push_back(OUT_W'(1));
    check_out("gap_dout");
    for (int i = 0; i < 4; i++) tick();
    check("gap_single", int'(dout_valid), 0);
    check("gap_level", int'(level), 0);
    check("sb_empty", exp_q.size(), 0);

    // report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
